// File: rtl/demultiplexor16bits1x4_reg.sv
// Registered 16-bit 1-to-4 demultiplexer with per-lane valid/ready output registers.
// The target lane is either the explicit select or an internal round-robin pointer.
module demultiplexor16bits1x4_reg #(
    parameter int unsigned ANCHO = 16
) (
    input  logic             Reloj,
    input  logic             Reset_n,
    input  logic [ANCHO-1:0] Entrada,
    input  logic             Entrada_Valida,
    output logic             Entrada_Lista,
    input  logic [1:0]       Seleccion,
    input  logic             Modo,
    output logic [ANCHO-1:0] TuplaA,
    output logic [ANCHO-1:0] TuplaB,
    output logic [ANCHO-1:0] TuplaC,
    output logic [ANCHO-1:0] TuplaD,
    output logic             ValidaA,
    output logic             ValidaB,
    output logic             ValidaC,
    output logic             ValidaD,
    input  logic             ListaA,
    input  logic             ListaB,
    input  logic             ListaC,
    input  logic             ListaD,
    output logic [1:0]       Puntero,
    output logic [7:0]       Cuenta
);

    logic [3:0][ANCHO-1:0] tupla_q, tupla_d;
    logic [3:0]            valida_q, valida_d;
    logic [1:0]            puntero_q, puntero_d;
    logic [7:0]            cuenta_q, cuenta_d;
    logic [3:0]            lista;
    logic [1:0]            destino;
    logic                  acepta;

    assign lista   = {ListaD, ListaC, ListaB, ListaA};
    assign destino = Modo ? puntero_q : Seleccion;

    // A full target that drains this cycle still accepts: no bubble on pass-through.
    assign Entrada_Lista = !valida_q[destino] || lista[destino];
    assign acepta        = Entrada_Valida && Entrada_Lista;

    always_comb begin
        tupla_d   = tupla_q;
        valida_d  = valida_q & ~lista;
        puntero_d = puntero_q;
        cuenta_d  = cuenta_q;
        if (acepta) begin
            tupla_d[destino]  = Entrada;
            valida_d[destino] = 1'b1;
            cuenta_d          = cuenta_q + 8'd1;
            if (Modo) begin
                puntero_d = puntero_q + 2'd1;
            end
        end
    end

    always_ff @(posedge Reloj or negedge Reset_n) begin
        if (!Reset_n) begin
            tupla_q   <= '0;
            valida_q  <= '0;
            puntero_q <= '0;
            cuenta_q  <= '0;
        end else begin
            tupla_q   <= tupla_d;
            valida_q  <= valida_d;
            puntero_q <= puntero_d;
            cuenta_q  <= cuenta_d;
        end
    end

    assign TuplaA  = tupla_q[0];
    assign TuplaB  = tupla_q[1];
    assign TuplaC  = tupla_q[2];
    assign TuplaD  = tupla_q[3];
    assign ValidaA = valida_q[0];
    assign ValidaB = valida_q[1];
    assign ValidaC = valida_q[2];
    assign ValidaD = valida_q[3];
    assign Puntero = puntero_q;
    assign Cuenta  = cuenta_q;

endmodule
